// File: rtl/counter_4b.sv
// Free-running 4-bit synchronous up-counter with a terminal-count ripple carry.
// Optional decade (0..9) mode when COUNTER_4B_DECADE_EN is defined.
module counter_4b #(
  parameter logic [3:0] RESET_VALUE = 4'b0000
) (
  input  logic clk,
  input  logic rst,
  output logic Qa,
  output logic Qb,
  output logic Qc,
  output logic Qd,
  output logic Rc
);

  logic [3:0] count_q;
  logic [3:0] count_d;
  logic [3:0] toggle;

  // Synchronous T-flip-flop chain: each bit toggles when all lower bits are 1.
  always_comb begin
    toggle  = {&count_q[2:0], &count_q[1:0], count_q[0], 1'b1};
    count_d = count_q ^ toggle;
`ifdef COUNTER_4B_DECADE_EN
    // 9 wraps to 0; illegal states 10..15 also recover to 0 on the next edge.
    if (count_q >= 4'd9) begin
      count_d = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign {Qd, Qc, Qb, Qa} = count_q;

`ifdef COUNTER_4B_DECADE_EN
  assign Rc = count_q[3] & count_q[0];
`else
  assign Rc = &count_q;
`endif

endmodule

// File: tb/tb_counter_4b.sv
// Scoreboard bench for counter_4b: two instances (reset value 0 and 14) against
// an arithmetic reference model; handles the COUNTER_4B_DECADE_EN build too.
module tb_counter_4b;

`ifdef COUNTER_4B_DECADE_EN
  localparam int MOD = 10;
`else
  localparam int MOD = 16;
`endif
  localparam int RV0 = 0;
  localparam int RV1 = 14;

  logic clk;
  logic rst;
  logic qa0, qb0, qc0, qd0, rc0;
  logic qa1, qb1, qc1, qd1, rc1;

  counter_4b #(.RESET_VALUE(4'd0)) u0 (
    .clk(clk), .rst(rst), .Qa(qa0), .Qb(qb0), .Qc(qc0), .Qd(qd0), .Rc(rc0)
  );
  counter_4b #(.RESET_VALUE(4'd14)) u1 (
    .clk(clk), .rst(rst), .Qa(qa1), .Qb(qb1), .Qc(qc1), .Qd(qd1), .Rc(rc1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int id;
    int v;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   m0, m1;

  function automatic int nxt(int v);
    if (v >= MOD - 1) return 0;
    return v + 1;
  endfunction

  function automatic int rc_of(int v);
`ifdef COUNTER_4B_DECADE_EN
    return (((v / 8) % 2) == 1 && (v % 2) == 1) ? 1 : 0;
`else
    return (v == 15) ? 1 : 0;
`endif
  endfunction

  task automatic push_both();
    exp_t e;
    e.id = 0; e.v = m0; sb.push_back(e);
    e.id = 1; e.v = m1; sb.push_back(e);
    ->sample_ev;
  endtask

  // Advance one clock; model counts only when reset is low at the edge.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      m0 = nxt(m0);
      m1 = nxt(m1);
    end
    @(negedge clk);
    push_both();
  endtask

  // Called mid-cycle: assert reset between edges and check its immediate effect.
  task automatic async_pulse(int hold);
    #2;
    rst = 1'b1;
    m0 = RV0;
    m1 = RV1;
    #1;
    push_both();
    repeat (hold) step();
    rst = 1'b0;
  endtask

  // Monitor: pops expectations and compares against the DUT outputs.
  initial begin
    exp_t e;
    int   act_q, act_rc;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.id == 0) begin
          act_q  = int'({qd0, qc0, qb0, qa0});
          act_rc = int'(rc0);
        end else begin
          act_q  = int'({qd1, qc1, qb1, qa1});
          act_rc = int'(rc1);
        end
        n_cmp++;
        if (act_q != e.v || act_rc != rc_of(e.v)) begin
          n_mis++;
          $display("FAIL count u%0d @%0t: got Q=%0d Rc=%0d, want Q=%0d Rc=%0d",
                   e.id, $time, act_q, act_rc, e.v, rc_of(e.v));
        end
      end
    end
  end

  initial begin
    int pulses, exp_pulses, hold;
    rst = 1'b1;
    m0  = RV0;
    m1  = RV1;
    #1;
    push_both();

    // Reset held over three clock periods
    repeat (3) step();
    rst = 1'b0;

    // Full sequence and wrap
    repeat (MOD + 1) step();

    // Run to count 7, then reset mid-cycle without a clock edge
    for (int i = 0; i < 40 && m0 != 7; i++) step();
    async_pulse(2);

    // Long run of 100 edges from reset, counting carry pulses
    pulses = 0;
    exp_pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rc0) pulses++;
      exp_pulses += rc_of(m0);
    end
    n_cmp++;
    if (pulses != exp_pulses) begin
      n_mis++;
      $display("FAIL rc_pulses: got %0d, want %0d", pulses, exp_pulses);
    end

    // Randomized run with random reset pulses
    for (int i = 0; i < 400; i++) begin
      step();
      if ($urandom_range(0, 24) == 0) begin
        hold = int'($urandom_range(0, 3));
        async_pulse(hold);
      end
    end

    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, want finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
